// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM decoding opcode into datapath selects and enables.
// Optional bne support is enabled by defining MULTICYCLE_BNE_EN.
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       pc_en,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StReset  = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StExec   = 4'd7,
        StRwb    = 4'd8,
        StBranch = 4'd9,
        StJump   = 4'd10,
        StAddiEx = 4'd11,
        StAddiWb = 4'd12
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
`ifdef MULTICYCLE_BNE_EN
    localparam logic [5:0] OpBne   = 6'b000101;
`endif

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       illegal_q, illegal_d;
    logic       bne_q;
    state_e     dec_state;
    logic       dec_legal;

    // Branch polarity follows the latched opcode, never the live one.
`ifdef MULTICYCLE_BNE_EN
    assign bne_q = (op_q == OpBne);
`else
    assign bne_q = 1'b0;
`endif

    // Dispatch target for the live opcode while in DECODE.
    always_comb begin
        dec_state = StFetch;
        dec_legal = 1'b1;
        case (opcode)
            OpLw, OpSw: dec_state = StMemAdr;
            OpRtype:    dec_state = StExec;
            OpBeq:      dec_state = StBranch;
            OpJ:        dec_state = StJump;
            OpAddi:     dec_state = StAddiEx;
`ifdef MULTICYCLE_BNE_EN
            OpBne:      dec_state = StBranch;
`endif
            default:    dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StReset;
            op_q      <= 6'b000000;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        case (state_q)
            StReset:  state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: begin
                op_d    = opcode;
                state_d = dec_state;
                if (!dec_legal) begin
                    illegal_d = 1'b1;
                end
            end
            StMemAdr: state_d = (op_q == OpLw) ? StMemRd : StMemWr;
            StMemRd:  state_d = StMemWb;
            StExec:   state_d = StRwb;
            StAddiEx: state_d = StAddiWb;
            StMemWb, StMemWr, StRwb, StBranch, StJump, StAddiWb: state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
            end
            StDecode: begin
                ALUSrcB    = 2'b11;
                instr_done = ~dec_legal;
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            StMemWb: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            StMemWr: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = 1'b1;
            end
            StExec: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            StRwb: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                ALUSrcA     = 1'b1;
                PCWriteCond = 1'b1;
                ALUOp       = 2'b01;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            StJump: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            StAddiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StAddiWb: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_en   = PCWrite | (PCWriteCond & (zero ^ bne_q));
    assign illegal = illegal_q;
    assign state   = state_q;

    mem_excl_a: assert property (@(posedge clk) disable iff (rst) !(MemRead && MemWrite));

endmodule
